// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score_keeper slice: FSM state encoding,
// winner codes and score width.
package score_pkg;

   typedef enum logic [1:0] {
      ST_PLAY    = 2'b00,
      ST_HOLDOFF = 2'b01,
      ST_OVER    = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } winner_t;

   localparam int SCORE_W                    = 3;
   localparam int CNT_W                      = 16;
   localparam int unsigned DEFAULT_WIN_SCORE = 5;

endpackage

// File: rtl/score_keeper_sync_rise.sv
// Two-flop synchroniser with a one-flop history, producing a one-cycle
// strobe on each rising edge of an asynchronous level.
module sync_rise (
   input  logic segclk,
   input  logic clr,
   input  logic din,
   output logic rise
);

   logic [1:0] sync;
   logic       hist;
   logic [2:0] arm;

   always_ff @(posedge segclk or posedge clr) begin
      if (clr) begin
         sync <= '0;
         hist <= 1'b0;
         arm  <= '0;
      end else begin
         sync <= {sync[0], din};
         hist <= sync[1];
         arm  <= {arm[1:0], 1'b1};
      end
   end

   // arm holds off the first edge after reset so a level already high when
   // clr releases loads the history flop instead of counting as a rise
   assign rise = sync[1] & ~hist & arm[2];

endmodule

// File: rtl/score_keeper.sv
// Two-player point counter: synchronised point/new-game edges drive a
// PLAY/HOLDOFF/OVER state machine with registered scores and status.
module score_keeper
   import score_pkg::*;
#(
   parameter int unsigned WIN_SCORE = DEFAULT_WIN_SCORE,
   parameter int unsigned HOLDOFF   = 256
) (
   input  logic               segclk,
   input  logic               clr,
   input  logic               p1_pt,
   input  logic               p2_pt,
   input  logic               new_game,
   output logic [SCORE_W-1:0] p1,
   output logic [SCORE_W-1:0] p2,
   output logic               game_over,
   output logic [1:0]         winner,
   output logic               serve,
   output logic               pt_pulse
);

   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLDOFF - 1);

   logic               p1_rise;
   logic               p2_rise;
   logic               ng_rise;
   logic [SCORE_W-1:0] p1_inc;
   logic [SCORE_W-1:0] p2_inc;
   logic [CNT_W-1:0]   cnt;
   state_t             state;

   sync_rise u_sync_p1 (.segclk(segclk), .clr(clr), .din(p1_pt),    .rise(p1_rise));
   sync_rise u_sync_p2 (.segclk(segclk), .clr(clr), .din(p2_pt),    .rise(p2_rise));
   sync_rise u_sync_ng (.segclk(segclk), .clr(clr), .din(new_game), .rise(ng_rise));

   always_comb begin
      p1_inc = p1 + SCORE_W'(1);
      p2_inc = p2 + SCORE_W'(1);
   end

   always_ff @(posedge segclk or posedge clr) begin
      if (clr) begin
         state     <= ST_PLAY;
         cnt       <= '0;
         p1        <= '0;
         p2        <= '0;
         game_over <= 1'b0;
         winner    <= WIN_NONE;
         serve     <= 1'b0;
         pt_pulse  <= 1'b0;
      end else begin
         pt_pulse <= 1'b0;
         if (ng_rise) begin
            state     <= ST_PLAY;
            cnt       <= '0;
            p1        <= '0;
            p2        <= '0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
            serve     <= 1'b0;
         end else begin
            case (state)
               ST_PLAY: begin
                  if (p1_rise && !p2_rise) begin
                     p1       <= p1_inc;
                     pt_pulse <= 1'b1;
                     serve    <= 1'b1;
                     if (p1_inc == WIN_VAL) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                        winner    <= WIN_P1;
                     end else begin
                        state <= ST_HOLDOFF;
                        cnt   <= HOLD_LOAD;
                     end
                  end else if (p2_rise && !p1_rise) begin
                     p2       <= p2_inc;
                     pt_pulse <= 1'b1;
                     serve    <= 1'b0;
                     if (p2_inc == WIN_VAL) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                        winner    <= WIN_P2;
                     end else begin
                        state <= ST_HOLDOFF;
                        cnt   <= HOLD_LOAD;
                     end
                  end
               end
               ST_HOLDOFF: begin
                  if (cnt == '0) begin
                     state <= ST_PLAY;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               ST_OVER: begin
                  game_over <= 1'b1;
               end
               default: begin
                  state <= ST_PLAY;
               end
            endcase
         end
      end
   end

endmodule
